mem_wait_responder: RTL and testbench

- Memory-side responder for the core's load/store bus: word-wide data memory with a request/ready handshake and a programmable number of wait states.
- Lets the multicycle datapath and control unit be exercised against realistic, non-zero memory latency.
- Sits between the core's address/write-data/write-enable outputs and its read-data input.
- Reports misaligned and out-of-range accesses on an error flag.

---
 rtl/mem_wait_responder.sv | 138 +++++++++++++
 tb/tb_mem_wait_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Word-wide data memory responder with request/ready handshake and WAIT_CYCLES wait states.
// Optional MEM_ACCESS_COUNT_EN adds an access_count output counting good transactions.
module mem_wait_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] access_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WC_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          go_resp;
  logic          commit;

  logic          lwe;
  logic [31:0]   la, lwd;
  logic [3:0]    lbe;

  logic          c_we;
  logic [31:0]   c_a, c_wd;
  logic [3:0]    c_be;
  logic          c_err;
  logic [AW-1:0] c_idx;

  logic [31:0]   mem [DEPTH];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    go_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_n = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WC_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_n = S_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the live inputs are used.
  always_comb begin
    c_we = lwe;
    c_a  = la;
    c_wd = lwd;
    c_be = lbe;
    if (state == S_IDLE) begin
      c_we = we;
      c_a  = a;
      c_wd = wd;
      c_be = be;
    end
  end

  assign c_err  = (c_a[1:0] != 2'b00) || (c_a[31:AW+2] != '0);
  assign c_idx  = c_a[AW+1:2];
  assign commit = go_resp && rst;
  assign ready  = (state == S_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      lwe   <= 1'b0;
      la    <= '0;
      lwd   <= '0;
      lbe   <= '0;
      rd    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == S_IDLE && req) begin
        lwe <= we;
        la  <= a;
        lwd <= wd;
        lbe <= be;
      end
      if (commit) begin
        rd  <= (!c_we && !c_err) ? mem[c_idx] : '0;
        err <= c_err;
      end else begin
        rd  <= '0;
        err <= 1'b0;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wd[8*i +: 8];
      end
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) access_count <= '0;
    else if (commit && !c_err) access_count <= access_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_wait_responder.sv
// Scoreboard bench for mem_wait_responder: one instance with 2 wait states, one with none.
module tb_mem_wait_responder;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] a, wd;
  logic [3:0]  be;
  int          sel;
  logic        req_a, req_b;
  logic [31:0] rd_a, rd_b;
  logic        ready_a, ready_b, err_a, err_b;
`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int last_rdy = -1;

  typedef struct {
    int          dut;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  assign req_a = req && (sel == 0);
  assign req_b = req && (sel == 1);

  mem_wait_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .a(a), .wd(wd), .be(be),
    .rd(rd_a), .ready(ready_a), .err(err_a)
`ifdef MEM_ACCESS_COUNT_EN
    , .access_count(cnt_a)
`endif
  );

  mem_wait_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .a(a), .wd(wd), .be(be),
    .rd(rd_b), .ready(ready_b), .err(err_b)
`ifdef MEM_ACCESS_COUNT_EN
    , .access_count(cnt_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation for every ready pulse, else requires quiet outputs.
  always @(negedge clk) begin
    logic        r;
    logic        e;
    logic [31:0] v;
    exp_t        x;
    for (int d = 0; d < 2; d++) begin
      r = (d == 0) ? ready_a : ready_b;
      v = (d == 0) ? rd_a : rd_b;
      e = (d == 0) ? err_a : err_b;
      if (r === 1'b1) begin
        if (sbq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_ready: dut %0d got ready=1 expected none (cycle %0d)", d, cyc);
        end else begin
          x = sbq.pop_front();
          check("resp_dut", d, x.dut);
          check("resp_rd", v, x.rd);
          check("resp_err", {31'd0, e}, {31'd0, x.err});
          check("resp_cycle", cyc, x.cyc);
        end
      end else begin
        check("idle_rd", v, 32'h0);
        check("idle_err", {31'd0, e}, 32'h0);
      end
    end
  end

  // Issue one transaction; returns on the falling edge where ready is seen.
  task automatic txn(input int d, input logic w, input logic [31:0] addr, input logic [31:0] dat,
                     input logic [3:0] b, input logic [31:0] erd, input logic eerr, input bit keep);
    int   acc;
    int   wc;
    bit   got;
    exp_t x;
    wc = (d == 0) ? 2 : 0;
    acc = (cyc == last_rdy) ? cyc + 2 : cyc + 1;
    x.dut = d; x.rd = erd; x.err = eerr; x.cyc = acc + wc;
    sbq.push_back(x);
    sel = d; we = w; a = addr; wd = dat; be = b; req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (((d == 0) ? ready_a : ready_b) === 1'b1) got = 1'b1;
    end
    nchk++;
    if (!got) begin
      nerr++;
      $display("FAIL ready_timeout: dut %0d addr %h got no ready expected ready", d, addr);
    end
    last_rdy = cyc;
    if (!keep) req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = 1'b0; sel = 0; we = 1'b0; a = '0; wd = '0; be = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_a", {31'd0, ready_a}, 32'h0);
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_err_a", {31'd0, err_a}, 32'h0);
    check("rst_ready_b", {31'd0, ready_b}, 32'h0);
`ifdef MEM_ACCESS_COUNT_EN
    check("rst_count", cnt_a, 32'h0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Basic write/read, byte strobes, no-op strobe, last word
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b0);
    txn(0, 1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 1'b0);

    // Error cases
    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    txn(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h80000004, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    txn(0, 1'b1, 32'h22, 32'h99999999, 4'hF, 32'h0, 1'b1, 1'b0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b0);

    // Zero wait states: setup, then three back-to-back reads with req held
    @(negedge clk);
    txn(1, 1'b1, 32'h0, 32'h00000001, 4'hF, 32'h0, 1'b0, 1'b0);
    txn(1, 1'b1, 32'h4, 32'h00000002, 4'hF, 32'h0, 1'b0, 1'b0);
    txn(1, 1'b1, 32'h8, 32'h00000003, 4'hF, 32'h0, 1'b0, 1'b0);
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h00000001, 1'b0, 1'b1);
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h00000002, 1'b0, 1'b1);
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'h00000003, 1'b0, 1'b0);

    // Abort: reset during the wait states of a write to 0x40
    @(negedge clk);
    txn(0, 1'b1, 32'h40, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    sel = 0; we = 1'b1; a = 32'h40; wd = 32'hFFFFFFFF; be = 4'hF; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_ready", {31'd0, ready_a}, 32'h0);
    check("abort_rd", rd_a, 32'h0);
`ifdef MEM_ACCESS_COUNT_EN
    check("abort_count", cnt_a, 32'h0);
`endif
    rst = 1'b1;
    repeat (4) @(negedge clk);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    txn(0, 1'b1, 32'h44, 32'h01020304, 4'hF, 32'h0, 1'b0, 1'b0);
`ifdef MEM_ACCESS_COUNT_EN
    check("count_after_4", cnt_a, 32'd3);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
